// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence engine: FSM state encoding
// and default term width / RAM depth.
package fib_pkg;

  localparam int FIB_DATA_W = 32;
  localparam int FIB_DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEED0,
    SEED1,
    CALC,
    FIN
  } fib_state_e;

endpackage

// File: rtl/fib_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (one-cycle) read. The read register clears on reset; the array does not.
module fib_dpram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci sequence generator that writes one term per cycle into a RAM and
// offers readback when idle. Define FIB_SAT_EN to saturate overflowing terms
// instead of wrapping them.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DEPTH  = FIB_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [DATA_W-1:0] last_term,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_2   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] LEN_3   = (ADDR_W+1)'(3);

  // Returns {carry, term}; the carry is kept even when the term saturates.
  function automatic logic [DATA_W:0] fib_add(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
`ifdef FIB_SAT_EN
    if (s[DATA_W]) s[DATA_W-1:0] = '1;
`endif
    return s;
  endfunction

  fib_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, wdata;
  logic [ADDR_W:0]   len_q, idx_q, len_clamped;
  logic [DATA_W:0]   sum;
  logic              accept, we, we_ram, done_d, ovf_hit;

  assign accept      = (state_q == IDLE) && start && !done;
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign sum         = fib_add(a_q, b_q);
  assign we_ram      = we && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    wdata   = a_q;
    ovf_hit = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = SEED0;
      SEED0: begin
        if (len_q == '0) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          we      = 1'b1;
          state_d = (len_q >= LEN_2) ? SEED1 : FIN;
        end
      end
      SEED1: begin
        we      = 1'b1;
        wdata   = b_q;
        state_d = (len_q >= LEN_3) ? CALC : FIN;
      end
      CALC: begin
        we      = 1'b1;
        wdata   = sum[DATA_W-1:0];
        ovf_hit = sum[DATA_W];
        if (idx_q == len_q - 1'b1) state_d = FIN;
      end
      // Zero-length runs already pulsed done when leaving SEED0.
      FIN: begin
        done_d  = (len_q != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      last_term <= '0;
      rd_valid  <= 1'b0;
    end else begin
      done     <= done_d;
      rd_valid <= rd_en && !busy;
      if (accept)      busy <= 1'b1;
      else if (done_d) busy <= 1'b0;
      if (accept)       ovf <= 1'b0;
      else if (ovf_hit) ovf <= 1'b1;
      if (we) last_term <= wdata;
    end
  end

  // Term history: a_q is term k-2, b_q is term k-1 once CALC is reached.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= seed0;
      b_q   <= seed1;
      len_q <= len_clamped;
      idx_q <= '0;
    end else if (we_ram) begin
      idx_q <= idx_q + 1'b1;
      if (state_q == CALC) begin
        a_q <= b_q;
        b_q <= sum[DATA_W-1:0];
      end
    end
  end

  fib_dpram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we_ram),
    .waddr(idx_q[ADDR_W-1:0]),
    .wdata(wdata),
    .re   (rd_en && !busy),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_fib_seq_engine.sv
// Scoreboard bench for fib_seq_engine: a stimulus process queues expected
// done/readback responses from an arithmetic model; a monitor pops and checks.
module tb_fib_seq_engine;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n, start, rd_en;
  logic [DATA_W-1:0] seed0, seed1;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy, done, ovf, rd_valid;
  logic [DATA_W-1:0] last_term, rd_data;

  always #5 clk = ~clk;

  fib_seq_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed0(seed0), .seed1(seed1),
    .len(len), .busy(busy), .done(done), .ovf(ovf), .last_term(last_term),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] last;
    logic        ovf;
    int unsigned edge_n;
  } done_exp_t;

  typedef struct {
    bit          known;
    logic [31:0] d;
  } rd_exp_t;

  done_exp_t   done_q[$];
  rd_exp_t     rd_q[$];
  logic [31:0] ref_mem[DEPTH];
  bit          ref_ok[DEPTH];
  logic [31:0] exp_last = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: terms by plain 64-bit arithmetic, overflow = sum beyond 32 bits.
  task automatic model_run(input logic [31:0] s0, input logic [31:0] s1,
                           input int l, output logic o);
    int n;
    longint unsigned p1, p2, t;
    n  = (l > DEPTH) ? DEPTH : l;
    o  = 1'b0;
    p1 = 0;
    p2 = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0)      t = longint'(s0);
      else if (k == 1) t = longint'(s1);
      else begin
        t = p1 + p2;
        if (t > 64'hFFFF_FFFF) begin
          o = 1'b1;
`ifdef FIB_SAT_EN
          t = 64'hFFFF_FFFF;
`else
          t = t & 64'hFFFF_FFFF;
`endif
        end
      end
      ref_mem[k] = t[31:0];
      ref_ok[k]  = 1'b1;
      exp_last   = t[31:0];
      p2 = p1;
      p1 = t;
    end
  endtask

  task automatic monitor();
    done_exp_t e;
    rd_exp_t   r;
    forever begin
      @(negedge clk);
      if (done) begin
        if (done_q.size() == 0) flag("unexpected_done");
        else begin
          e = done_q.pop_front();
          chk("done_edge", 64'(edge_cnt), 64'(e.edge_n));
          chk("last_term", 64'(last_term), 64'(e.last));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) flag("unexpected_rd_valid");
        else begin
          r = rd_q.pop_front();
          if (r.known) chk("rd_data", 64'(rd_data), 64'(r.d));
        end
      end
    end
  endtask

  task automatic run(input logic [31:0] s0, input logic [31:0] s1,
                     input int l, input bit disturb);
    int unsigned t0;
    int          n;
    logic        o;
    done_exp_t   e;
    bit          timed_out;
    @(negedge clk);
    start = 1'b1; seed0 = s0; seed1 = s1; len = 6'(l);
    t0 = edge_cnt + 1;
    model_run(s0, s1, l, o);
    n = (l > DEPTH) ? DEPTH : l;
    e.last = exp_last; e.ovf = o; e.edge_n = t0 + n + 1;
    done_q.push_back(e);
    @(negedge clk);
    start = 1'b0; seed0 = $urandom; seed1 = $urandom; len = 6'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
    for (int i = 0; i < 80 && busy; i++) begin
      if (disturb && i == 2) begin
        start = 1'b1; rd_en = 1'b1; rd_addr = 5'($urandom);
      end else begin
        start = 1'b0; rd_en = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; rd_en = 1'b0;
    timed_out = busy;
    if (timed_out) flag("busy_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic rd(input int a, input bit known, input logic [31:0] v);
    rd_exp_t r;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 5'(a);
    r.known = known; r.d = v;
    rd_q.push_back(r);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic rd_ref(input int a);
    rd(a, ref_ok[a], ref_mem[a]);
  endtask

  task automatic abort_run();
    int unsigned t0;
    logic        o;
    @(negedge clk);
    start = 1'b1; seed0 = 32'd3; seed1 = 32'd4; len = 6'd20;
    t0 = edge_cnt + 1;
    model_run(32'd3, 32'd4, 4, o);
    ref_ok[4] = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (edge_cnt < t0 + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_last_term", 64'(last_term), 64'(0));
    rst_n = 1'b1;
    exp_last = '0;
    repeat (3) @(negedge clk);
    chk("abort_busy_after", 64'(busy), 64'(0));
  endtask

  task automatic stimulus();
    rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    seed0 = '0; seed1 = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) ref_ok[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_last_term", 64'(last_term), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run(32'd0, 32'd1, 30, 1'b0);
    rd(29, 1'b1, 32'd514229);
    rd(10, 1'b1, 32'd55);
    chk("s1_last_term", 64'(last_term), 64'(514229));

    run(32'hF000_0000, 32'h2000_0000, 10, 1'b0);
    chk("ovf_set", 64'(ovf), 64'(1));
    rd_ref(9);

    run(32'd77, 32'd88, 0, 1'b0);
    rd_ref(0);
    run(32'd1234, 32'd99, 1, 1'b0);
    rd_ref(0);
    rd_ref(1);
    run(32'd2, 32'd3, 40, 1'b0);
    rd_ref(31);
    run($urandom, $urandom, 30, 1'b1);
    rd_ref(12);

    for (int i = 0; i < 6; i++) begin
      run($urandom, $urandom_range(0, 1000), $urandom_range(0, 40), 1'b0);
      rd_ref($urandom_range(0, DEPTH - 1));
    end

    abort_run();
    run(32'd5, 32'd8, 12, 1'b0);
    for (int i = 0; i < DEPTH; i += 3) rd_ref(i);

    repeat (4) @(negedge clk);
    if (done_q.size() != 0) flag("done_missing");
    if (rd_q.size() != 0) flag("rd_valid_missing");
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
